gfx_fb_writer: RTL and testbench
================================

# gfx_fb_writer

Downstream stage for the graphics pixel stream: it accepts (x, y, pixel) beats from a gfx producer such as the shape/line/rect-fill engines and turns them into linear framebuffer write requests. It discards beats that fall outside the visible area and computes the address as y × h_visible + x. A two-stage registered pipeline with full backpressure places it between the gfx master and the framebuffer memory write port.

## Interface
Parameters:
- H_WIDTH, 12, x coordinate width
- V_WIDTH, 12, y coordinate width
- PIXEL_WIDTH, 12, pixel data width
- ADDR_WIDTH, 20, framebuffer word address width

Ports:
- clk  input  1  clock; all logic is on its rising edge
- rst  input  1  reset, asynchronous and active-high
- s_gfx_valid  input  1  input beat valid
- s_gfx_x  input  H_WIDTH  pixel x
- s_gfx_y  input  V_WIDTH  pixel y
- s_gfx_pixel  input  PIXEL_WIDTH  pixel color
- s_gfx_ready  output  1  block can accept a beat this cycle
- h_visible  input  H_WIDTH  visible width, used as clip bound and row stride
- v_visible  input  V_WIDTH  visible height, used as clip bound
- m_mem_wr_valid  output  1  write request valid
- m_mem_wr_addr  output  ADDR_WIDTH  word address
- m_mem_wr_data  output  PIXEL_WIDTH  write data
- m_mem_wr_ready  input  1  memory accepts the request
- clip_count  output  16  number of beats discarded by clipping; saturates
- idle  output  1  no beat in flight

## Operation
- A beat is accepted (handshake) when s_gfx_valid and s_gfx_ready are both high.
- Stage 1 (S1) registers: v1, x1, y1, pix1, hv1. hv1 holds the h_visible value sampled at acceptance.
  - Accepted beat with s_gfx_x < h_visible and s_gfx_y < v_visible: loads S1 and sets v1.
  - Accepted beat out of bounds (x ≥ h_visible or y ≥ v_visible): is consumed but v1 is not set, and clip_count increments. Bounds are exclusive, so x == h_visible is clipped.
- Stage 2 (S2) is the output registers. m_mem_wr_addr = y1 × hv1 + x1.
  - The product is computed at full width (H_WIDTH+V_WIDTH), then truncated to the low ADDR_WIDTH bits. There is no overflow flag.
  - m_mem_wr_data = pix1.
- Ready chain:
  - s2_ready = !m_mem_wr_valid || m_mem_wr_ready
  - s1_ready = !v1 || s2_ready
  - s_gfx_ready = s1_ready. This is combinational from m_mem_wr_ready.
- S1 advances into S2 when v1 && s2_ready.
  - If S1 is not refilled in the same cycle, v1 clears.
  - S2 clears when m_mem_wr_ready is high and nothing advances.
- While m_mem_wr_valid && !m_mem_wr_ready, addr and data must hold stable.
- Order is preserved. No beat is duplicated or lost, except beats dropped by clipping.
- clip_count increments by 1 per clipped accepted beat and saturates at 16'hFFFF. It is cleared only by reset.
- idle = !v1 && !m_mem_wr_valid.
- Changes to h_visible or v_visible take effect for beats accepted from the next handshake onward. In-flight beats keep their sampled stride.

## Timing
- Reset values: m_mem_wr_valid 0, m_mem_wr_addr 0, m_mem_wr_data 0, clip_count 0, idle 1. s_gfx_ready is 1 out of reset.
- Reset is asynchronous: asserting rst mid-stream clears v1, m_mem_wr_valid and clip_count immediately. In-flight beats are dropped.
- Latency: a beat accepted at edge N appears on m_mem_wr_valid after edge N+1 (2-cycle register latency). This assumes no stall.
- Throughput is 1 beat per cycle with m_mem_wr_ready held high.
- Stall: when m_mem_wr_ready is low, at most 2 beats are held (one in S1, one in S2), and s_gfx_ready then goes low.
- On release: m_mem_wr_ready rising lets S2 drain, S1 advance and the input accept, all in the same cycle. No bubble is inserted.
- Simultaneous events:
  - A clipped accept in the same cycle as an S1→S2 advance: v1 clears and clip_count increments.
  - At saturation, clip_count holds at FFFF.

## Test plan
- Single beat: h_visible=640, v_visible=480, beat x=3 y=2 pixel=12'hABC → one write with addr=1283 and data=ABC, valid 2 cycles after the handshake, and idle returns high.
- Clipping: beats (640,0), (0,480) and (639,479) → only one write, addr=307199. clip_count=2.
- Backpressure: stream 6 beats with m_mem_wr_ready low for 5 cycles → s_gfx_ready low after 2 beats are held, outputs stable throughout. After release, all 6 writes arrive in order with no gaps.
- Full frame: raster 640×480 with ready toggling pseudo-randomly → exactly 307200 writes, addresses 0..307199 each exactly once, clip_count=0.
- Saturation and reset: feed 65540 clipped beats → clip_count=FFFF. Then assert rst asynchronously mid-stall → immediately valid=0, clip_count=0, idle=1.

Source files
------------

// File: rtl/gfx_fb_writer.sv
// Pixel-stream to framebuffer write adapter: clips (x, y, pixel) beats to the
// visible area and issues linear word writes through a two-stage skid-free pipeline.
module gfx_fb_writer #(
  parameter int H_WIDTH     = 12,
  parameter int V_WIDTH     = 12,
  parameter int PIXEL_WIDTH = 12,
  parameter int ADDR_WIDTH  = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_gfx_valid,
  input  logic [H_WIDTH-1:0]     s_gfx_x,
  input  logic [V_WIDTH-1:0]     s_gfx_y,
  input  logic [PIXEL_WIDTH-1:0] s_gfx_pixel,
  output logic                   s_gfx_ready,
  input  logic [H_WIDTH-1:0]     h_visible,
  input  logic [V_WIDTH-1:0]     v_visible,
  output logic                   m_mem_wr_valid,
  output logic [ADDR_WIDTH-1:0]  m_mem_wr_addr,
  output logic [PIXEL_WIDTH-1:0] m_mem_wr_data,
  input  logic                   m_mem_wr_ready,
  output logic [15:0]            clip_count,
  output logic                   idle
);

  localparam int PW = H_WIDTH + V_WIDTH;

  logic                   v1_q, v1_d;
  logic [H_WIDTH-1:0]     x1_q, x1_d;
  logic [V_WIDTH-1:0]     y1_q, y1_d;
  logic [PIXEL_WIDTH-1:0] pix1_q, pix1_d;
  logic [H_WIDTH-1:0]     hv1_q, hv1_d;
  logic                   wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [PIXEL_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [15:0]            clip_q, clip_d;

  logic          s2_ready;
  logic          s1_ready;
  logic          accept;
  logic          in_bounds;
  logic          load_s1;
  logic          advance;
  logic [PW-1:0] addr_full;

  always_comb begin
    s2_ready  = !wr_valid_q || m_mem_wr_ready;
    s1_ready  = !v1_q || s2_ready;
    accept    = s_gfx_valid && s1_ready;
    in_bounds = (s_gfx_x < h_visible) && (s_gfx_y < v_visible);
    load_s1   = accept && in_bounds;
    advance   = v1_q && s2_ready;
    // Full-width product so truncation only happens at the address port.
    addr_full = PW'(y1_q) * PW'(hv1_q) + PW'(x1_q);
  end

  always_comb begin
    v1_d   = v1_q;
    x1_d   = x1_q;
    y1_d   = y1_q;
    pix1_d = pix1_q;
    hv1_d  = hv1_q;
    if (load_s1) begin
      v1_d   = 1'b1;
      x1_d   = s_gfx_x;
      y1_d   = s_gfx_y;
      pix1_d = s_gfx_pixel;
      hv1_d  = h_visible;
    end else if (s2_ready) begin
      v1_d = 1'b0;
    end
  end

  // Address and data only change on advance, so they stay put during a stall.
  always_comb begin
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (advance) begin
      wr_valid_d = 1'b1;
      wr_addr_d  = ADDR_WIDTH'(addr_full);
      wr_data_d  = pix1_q;
    end else if (m_mem_wr_ready) begin
      wr_valid_d = 1'b0;
    end
  end

  always_comb begin
    clip_d = clip_q;
    if (accept && !in_bounds && (clip_q != 16'hFFFF)) begin
      clip_d = clip_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q       <= 1'b0;
      x1_q       <= '0;
      y1_q       <= '0;
      pix1_q     <= '0;
      hv1_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      clip_q     <= '0;
    end else begin
      v1_q       <= v1_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      pix1_q     <= pix1_d;
      hv1_q      <= hv1_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      clip_q     <= clip_d;
    end
  end

  assign s_gfx_ready    = s1_ready;
  assign m_mem_wr_valid = wr_valid_q;
  assign m_mem_wr_addr  = wr_addr_q;
  assign m_mem_wr_data  = wr_data_q;
  assign clip_count     = clip_q;
  assign idle           = !v1_q && !wr_valid_q;

endmodule

// File: tb/tb_gfx_fb_writer.sv
// Directed bench for gfx_fb_writer: hand-computed addresses, clipping,
// backpressure, a small raster with random stalls, saturation and async reset.
module tb_gfx_fb_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_gfx_valid;
  logic [11:0] s_gfx_x;
  logic [11:0] s_gfx_y;
  logic [11:0] s_gfx_pixel;
  logic        s_gfx_ready;
  logic [11:0] h_visible;
  logic [11:0] v_visible;
  logic        m_mem_wr_valid;
  logic [19:0] m_mem_wr_addr;
  logic [11:0] m_mem_wr_data;
  logic        m_mem_wr_ready;
  logic [15:0] clip_count;
  logic        idle;

  int vectors = 0;
  int miscompares = 0;

  gfx_fb_writer #(
    .H_WIDTH(12), .V_WIDTH(12), .PIXEL_WIDTH(12), .ADDR_WIDTH(20)
  ) dut (
    .clk(clk), .rst(rst),
    .s_gfx_valid(s_gfx_valid), .s_gfx_x(s_gfx_x), .s_gfx_y(s_gfx_y),
    .s_gfx_pixel(s_gfx_pixel), .s_gfx_ready(s_gfx_ready),
    .h_visible(h_visible), .v_visible(v_visible),
    .m_mem_wr_valid(m_mem_wr_valid), .m_mem_wr_addr(m_mem_wr_addr),
    .m_mem_wr_data(m_mem_wr_data), .m_mem_wr_ready(m_mem_wr_ready),
    .clip_count(clip_count), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input int x, input int y, input int pix);
    s_gfx_valid = v;
    s_gfx_x     = 12'(x);
    s_gfx_y     = 12'(y);
    s_gfx_pixel = 12'(pix);
  endtask

  initial begin
    int  idx;
    int  w;
    int  cyc;
    logic        prev_stall;
    logic [19:0] prev_addr;

    rst = 1'b1;
    beat(1'b0, 0, 0, 0);
    h_visible = 12'd640;
    v_visible = 12'd480;
    m_mem_wr_ready = 1'b1;
    #12;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(m_mem_wr_valid), 0);
    chk("rst_addr", 32'(m_mem_wr_addr), 0);
    chk("rst_data", 32'(m_mem_wr_data), 0);
    chk("rst_clip", 32'(clip_count), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_ready", 32'(s_gfx_ready), 1);

    // Single beat: 2*640+3 = 1283
    step(); beat(1'b1, 3, 2, 12'hABC);
    @(negedge clk); chk("single_sready", 32'(s_gfx_ready), 1);
    step(); beat(1'b0, 0, 0, 0);
    @(negedge clk); chk("single_lat1_valid", 32'(m_mem_wr_valid), 0); chk("single_lat1_idle", 32'(idle), 0);
    step();
    @(negedge clk);
    chk("single_valid", 32'(m_mem_wr_valid), 1);
    chk("single_addr", 32'(m_mem_wr_addr), 1283);
    chk("single_data", 32'(m_mem_wr_data), 32'hABC);
    step();
    @(negedge clk); chk("single_done_valid", 32'(m_mem_wr_valid), 0); chk("single_done_idle", 32'(idle), 1);

    // Clipping: x==h and y==v are dropped, (639,479) -> 479*640+639 = 307199
    step(); beat(1'b1, 640, 0, 1);
    @(negedge clk); chk("clip_a_valid", 32'(m_mem_wr_valid), 0);
    step(); beat(1'b1, 0, 480, 2);
    @(negedge clk); chk("clip_b_valid", 32'(m_mem_wr_valid), 0); chk("clip_b_count", 32'(clip_count), 1);
    step(); beat(1'b1, 639, 479, 12'h5A5);
    @(negedge clk); chk("clip_c_valid", 32'(m_mem_wr_valid), 0); chk("clip_c_count", 32'(clip_count), 2);
    step(); beat(1'b0, 0, 0, 0);
    @(negedge clk); chk("clip_s1_valid", 32'(m_mem_wr_valid), 0);
    step();
    @(negedge clk);
    chk("clip_wr_valid", 32'(m_mem_wr_valid), 1);
    chk("clip_wr_addr", 32'(m_mem_wr_addr), 307199);
    chk("clip_wr_data", 32'(m_mem_wr_data), 32'h5A5);
    chk("clip_final_count", 32'(clip_count), 2);
    step();
    @(negedge clk); chk("clip_done_valid", 32'(m_mem_wr_valid), 0);

    // Truncation: 4094*4095+4094 = 0xFFE000 -> low 20 bits 0xFE000; then a
    // clipped x==4095 beat arrives while the first beat advances to S2
    h_visible = 12'd4095;
    v_visible = 12'd4095;
    step(); beat(1'b1, 4094, 4094, 12'h777);
    step(); beat(1'b1, 4095, 0, 12'h123);
    step(); beat(1'b0, 0, 0, 0);
    @(negedge clk);
    chk("trunc_valid", 32'(m_mem_wr_valid), 1);
    chk("trunc_addr", 32'(m_mem_wr_addr), 32'hFE000);
    chk("trunc_data", 32'(m_mem_wr_data), 32'h777);
    chk("trunc_clip", 32'(clip_count), 3);
    step();
    @(negedge clk); chk("trunc_idle", 32'(idle), 1);

    // In-flight beat keeps its sampled stride: 1*100+1, then 1*200+1
    v_visible = 12'd480;
    step(); beat(1'b1, 1, 1, 12'h011); h_visible = 12'd100;
    step(); beat(1'b1, 1, 1, 12'h022); h_visible = 12'd200;
    step(); beat(1'b0, 0, 0, 0); h_visible = 12'd50;
    @(negedge clk); chk("stride_a_addr", 32'(m_mem_wr_addr), 101); chk("stride_a_valid", 32'(m_mem_wr_valid), 1);
    step();
    @(negedge clk); chk("stride_b_addr", 32'(m_mem_wr_addr), 201); chk("stride_b_data", 32'(m_mem_wr_data), 32'h022);
    step();
    @(negedge clk); chk("stride_idle", 32'(idle), 1);

    // Backpressure: beats x=10+i,y=1 -> addr 650+i, ready low for cycles 0..4
    h_visible = 12'd640;
    idx = 0;
    w = 0;
    for (cyc = 0; cyc < 13; cyc++) begin
      step();
      m_mem_wr_ready = (cyc >= 5);
      beat(idx < 6, 10 + idx, 1, 12'h100 + idx);
      @(negedge clk);
      if (cyc >= 2 && cyc <= 4) begin
        chk("bp_stall_sready", 32'(s_gfx_ready), 0);
        chk("bp_stall_addr", 32'(m_mem_wr_addr), 650);
        chk("bp_stall_data", 32'(m_mem_wr_data), 32'h100);
      end
      if (cyc >= 5 && cyc <= 10) chk("bp_no_gap", 32'(m_mem_wr_valid), 1);
      if (m_mem_wr_valid && m_mem_wr_ready) begin
        chk("bp_order_addr", 32'(m_mem_wr_addr), 32'(650 + w));
        chk("bp_order_data", 32'(m_mem_wr_data), 32'(12'h100 + w));
        w++;
      end
      if (s_gfx_valid && s_gfx_ready) idx++;
    end
    chk("bp_writes", 32'(w), 6);
    chk("bp_accepts", 32'(idx), 6);
    chk("bp_idle", 32'(idle), 1);

    // Reset, then a 32x24 raster with random ready and valid gaps
    step(); rst = 1'b1; beat(1'b0, 0, 0, 0);
    #2 rst = 1'b0;
    @(negedge clk); chk("frame_rst_clip", 32'(clip_count), 0);
    h_visible = 12'd32;
    v_visible = 12'd24;
    idx = 0;
    w = 0;
    prev_stall = 1'b0;
    prev_addr = '0;
    for (cyc = 0; cyc < 6000 && w < 768; cyc++) begin
      step();
      m_mem_wr_ready = 1'($urandom_range(0, 1));
      beat((idx < 768) && ($urandom_range(0, 3) != 0), idx % 32, idx / 32, idx);
      @(negedge clk);
      if (prev_stall) chk("frame_stall_stable", 32'(m_mem_wr_addr), 32'(prev_addr));
      prev_stall = m_mem_wr_valid && !m_mem_wr_ready;
      prev_addr = m_mem_wr_addr;
      if (m_mem_wr_valid && m_mem_wr_ready) begin
        chk("frame_addr", 32'(m_mem_wr_addr), 32'(w));
        chk("frame_data", 32'(m_mem_wr_data), 32'(w % 4096));
        w++;
      end
      if (s_gfx_valid && s_gfx_ready) idx++;
    end
    chk("frame_writes", 32'(w), 768);
    chk("frame_clip", 32'(clip_count), 0);
    step(); m_mem_wr_ready = 1'b1; beat(1'b0, 0, 0, 0);
    @(negedge clk); chk("frame_idle", 32'(idle), 1);

    // Saturation: 65534 clipped beats, then 6 more
    h_visible = 12'd640;
    v_visible = 12'd480;
    step(); beat(1'b1, 640, 0, 0);
    repeat (65534) @(posedge clk);
    @(negedge clk); chk("sat_fffe", 32'(clip_count), 32'hFFFE);
    repeat (6) @(posedge clk);
    @(negedge clk); chk("sat_ffff", 32'(clip_count), 32'hFFFF);

    // Async reset mid-stall
    step(); m_mem_wr_ready = 1'b0; beat(1'b1, 5, 5, 1);
    step(); beat(1'b1, 6, 5, 2);
    step(); beat(1'b0, 0, 0, 0);
    @(negedge clk);
    chk("stall_valid", 32'(m_mem_wr_valid), 1);
    chk("stall_sready", 32'(s_gfx_ready), 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(m_mem_wr_valid), 0);
    chk("arst_clip", 32'(clip_count), 0);
    chk("arst_idle", 32'(idle), 1);
    chk("arst_sready", 32'(s_gfx_ready), 1);
    step(); rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
